// File: rtl/ad_ip_jesd204_tpl_adc_pn_scan_pkg.sv
// ad_ip_jesd204_tpl_adc_pn_scan_pkg: shared state encoding and PN select constants for the PN scan sequencer.
package ad_ip_jesd204_tpl_adc_pn_scan_pkg;
  typedef enum logic [2:0] {IDLE, SELECT, SYNC, MEASURE, REPORT, DONE} state_t;
  localparam logic [3:0] PN9 = 4'd0;
  localparam logic [3:0] PN23 = 4'd1;
  function automatic int max_i(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_pn_err_cnt.sv
// ad_ip_jesd204_tpl_adc_pn_err_cnt: saturating error counter with clear/enable; exposes its next value so the final window cycle is captured on the same edge.
module ad_ip_jesd204_tpl_adc_pn_err_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt_nxt
);
  logic [W-1:0] cnt_q;
  always_comb cnt_nxt = clr ? '0 : (en && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_nxt;
endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_pn_scan.sv
// ad_ip_jesd204_tpl_adc_pn_scan: steps one shared PN monitor across all ADC channels and reports per-channel lock/error results.
module ad_ip_jesd204_tpl_adc_pn_scan
  import ad_ip_jesd204_tpl_adc_pn_scan_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int ERR_CNT_WIDTH = 16,
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [3:0]               cfg_pn_seq_sel,
  input  logic [15:0]              cfg_window_len,
  output logic [CW-1:0]            mon_chan_sel,
  output logic [3:0]               mon_pn_seq_sel,
  input  logic                     mon_pn_oos,
  input  logic                     mon_pn_err,
  output logic                     busy,
  output logic                     done,
  output logic                     result_valid,
  output logic [CW-1:0]            result_chan,
  output logic                     result_lock,
  output logic                     result_timeout,
  output logic [ERR_CNT_WIDTH-1:0] result_err_cnt,
  output logic [NUM_CHANNELS-1:0]  chan_lock_mask
);
  localparam int CNT_W = max_i(16, max_i($clog2(SETTLE_CYCLES + 1), $clog2(LOCK_TIMEOUT + 1)));
  localparam logic [CW-1:0] LAST = CW'(NUM_CHANNELS - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic lock_q, lock_d;
  logic [15:0] win_q, win_d;
  logic busy_q, busy_d, done_q, done_d, rv_q, rv_d;
  logic [CW-1:0] rchan_q, rchan_d, sel_q, sel_d;
  logic rlock_q, rlock_d, rto_q, rto_d;
  logic [ERR_CNT_WIDTH-1:0] rerr_q, rerr_d, rep_err, err_nxt;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic [3:0] pn_q, pn_d;
  logic rep, rep_lock, rep_to, kill, err_clr, err_en;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign err_clr = state_q != MEASURE;
  assign err_en = state_q == MEASURE && (mon_pn_err || mon_pn_oos);
  ad_ip_jesd204_tpl_adc_pn_err_cnt #(.W(ERR_CNT_WIDTH)) u_err_cnt (
    .clk(clk),
    .reset(reset),
    .clr(err_clr),
    .en(err_en),
    .cnt_nxt(err_nxt)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    lock_d = lock_q;
    win_d = win_q;
    busy_d = busy_q;
    done_d = 1'b0;
    rv_d = 1'b0;
    rchan_d = rchan_q;
    rlock_d = rlock_q;
    rto_d = rto_q;
    rerr_d = rerr_q;
    mask_d = mask_q;
    sel_d = sel_q;
    pn_d = pn_q;
    rep = 1'b0;
    rep_lock = 1'b0;
    rep_to = 1'b0;
    rep_err = '0;
    case (state_q)
      IDLE: if (start && !abort) begin
        state_d = SELECT;
        busy_d = 1'b1;
        cnt_d = '0;
        sel_d = '0;
        mask_d = '0;
        win_d = cfg_window_len;
        pn_d = cfg_pn_seq_sel == PN9 ? PN9 : PN23;
      end
      SELECT: begin
        state_d = cnt_q == CNT_W'(SETTLE_CYCLES - 1) ? SYNC : SELECT;
        cnt_d = cnt_q == CNT_W'(SETTLE_CYCLES - 1) ? '0 : cnt_inc;
      end
      SYNC: if (!mon_pn_oos) begin
        // A zero-length window reports a clean lock without measuring.
        state_d = win_q == '0 ? REPORT : MEASURE;
        rep = win_q == '0;
        rep_lock = 1'b1;
        lock_d = 1'b1;
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
        state_d = REPORT;
        rep = 1'b1;
        rep_to = 1'b1;
      end else cnt_d = cnt_inc;
      MEASURE: begin
        lock_d = lock_q & ~mon_pn_oos;
        if (cnt_inc == CNT_W'(win_q)) begin
          state_d = REPORT;
          rep = 1'b1;
          rep_lock = lock_d;
          rep_err = err_nxt;
        end else cnt_d = cnt_inc;
      end
      REPORT: begin
        state_d = sel_q == LAST ? DONE : SELECT;
        done_d = sel_q == LAST;
        sel_d = sel_q == LAST ? sel_q : sel_q + CW'(1);
        cnt_d = '0;
      end
      DONE: begin
        state_d = IDLE;
        busy_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    kill = abort && busy_q;
    if (kill) begin
      state_d = IDLE;
      busy_d = 1'b0;
      done_d = 1'b0;
    end
    if (rep && !kill) begin
      rv_d = 1'b1;
      rchan_d = sel_q;
      rlock_d = rep_lock;
      rto_d = rep_to;
      rerr_d = rep_err;
      mask_d[sel_q] = rep_lock;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      lock_q <= 1'b0;
      win_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rv_q <= 1'b0;
      rchan_q <= '0;
      rlock_q <= 1'b0;
      rto_q <= 1'b0;
      rerr_q <= '0;
      mask_q <= '0;
      sel_q <= '0;
      pn_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      lock_q <= lock_d;
      win_q <= win_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rv_q <= rv_d;
      rchan_q <= rchan_d;
      rlock_q <= rlock_d;
      rto_q <= rto_d;
      rerr_q <= rerr_d;
      mask_q <= mask_d;
      sel_q <= sel_d;
      pn_q <= pn_d;
    end
  assign mon_chan_sel = sel_q;
  assign mon_pn_seq_sel = pn_q;
  assign busy = busy_q;
  assign done = done_q;
  assign result_valid = rv_q;
  assign result_chan = rchan_q;
  assign result_lock = rlock_q;
  assign result_timeout = rto_q;
  assign result_err_cnt = rerr_q;
  assign chan_lock_mask = mask_q;
endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_pn_scan.sv
// tb_ad_ip_jesd204_tpl_adc_pn_scan: directed scans against a behavioural PN monitor, with a scoreboard of expected per-channel results.
module tb_ad_ip_jesd204_tpl_adc_pn_scan;
  localparam int SET = 8;
  localparam int TO = 1024;
  localparam int W = 100;
  localparam int LW = SET + 4 + W;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] pn = 4'd0;
  logic [15:0] win = 16'd0;
  logic [1:0] mon_chan_sel, result_chan, last_sel = 2'd0;
  logic [3:0] mon_pn_seq_sel, chan_lock_mask, bad_chan = 4'd0;
  logic mon_pn_oos, mon_pn_err, busy, done, result_valid, result_lock, result_timeout, last_busy = 1'b0;
  logic [15:0] result_err_cnt;
  logic s_start = 1'b0, s_abort = 1'b0, s_oos = 1'b0, s_err = 1'b1;
  logic [15:0] s_win = 16'd40;
  logic [0:0] s_sel, s_rchan, s_mask;
  logic [3:0] s_pn, s_rerr;
  logic s_busy, s_done, s_rv, s_rlock, s_rto;
  int err_chan = -1, since = 0, total = 0, bad = 0, cyc = 0, last_evt = 0, done_cnt = 0, rv_cnt = 0;
  typedef struct {int chan; logic lock; logic to; int err; int dly;} exp_t;
  exp_t sb[$];
  exp_t e;

  ad_ip_jesd204_tpl_adc_pn_scan #(.NUM_CHANNELS(4), .SETTLE_CYCLES(SET), .LOCK_TIMEOUT(TO), .ERR_CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_pn_seq_sel(pn), .cfg_window_len(win),
    .mon_chan_sel(mon_chan_sel), .mon_pn_seq_sel(mon_pn_seq_sel), .mon_pn_oos(mon_pn_oos), .mon_pn_err(mon_pn_err),
    .busy(busy), .done(done), .result_valid(result_valid), .result_chan(result_chan), .result_lock(result_lock),
    .result_timeout(result_timeout), .result_err_cnt(result_err_cnt), .chan_lock_mask(chan_lock_mask));

  ad_ip_jesd204_tpl_adc_pn_scan #(.NUM_CHANNELS(1), .SETTLE_CYCLES(2), .LOCK_TIMEOUT(16), .ERR_CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset(reset), .start(s_start), .abort(s_abort), .cfg_pn_seq_sel(4'd0), .cfg_window_len(s_win),
    .mon_chan_sel(s_sel), .mon_pn_seq_sel(s_pn), .mon_pn_oos(s_oos), .mon_pn_err(s_err),
    .busy(s_busy), .done(s_done), .result_valid(s_rv), .result_chan(s_rchan), .result_lock(s_rlock),
    .result_timeout(s_rto), .result_err_cnt(s_rerr), .chan_lock_mask(s_mask));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor model: re-acquires sync SET+2 cycles after the mux moves or a scan begins.
  always @(posedge clk) begin
    since <= ((busy && !last_busy) || mon_chan_sel != last_sel) ? 0 : since + 1;
    last_busy <= busy;
    last_sel <= mon_chan_sel;
  end
  assign mon_pn_oos = bad_chan[mon_chan_sel] || since < SET + 2 || (err_chan == int'(mon_chan_sel) && since == 30);
  assign mon_pn_err = err_chan == int'(mon_chan_sel) && since >= 20 && since < 25;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int c, input logic l, input logic t, input int er, input int d);
    exp_t x;
    x.chan = c;
    x.lock = l;
    x.to = t;
    x.err = er;
    x.dly = d;
    sb.push_back(x);
  endtask

  task automatic push_clean();
    push(0, 1'b1, 1'b0, 0, LW);
    for (int c = 1; c < 4; c++) push(c, 1'b1, 1'b0, 0, LW + 1);
  endtask

  task automatic scan(input logic [3:0] p, input logic [15:0] w);
    pn = p;
    win = w;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    last_evt = cyc;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("scan_finished", 32'(busy), 0);
  endtask

  task automatic chk_zero(input string ph);
    chk({ph, "_busy"}, 32'(busy), 0);
    chk({ph, "_done"}, 32'(done), 0);
    chk({ph, "_rv"}, 32'(result_valid), 0);
    chk({ph, "_rchan"}, 32'(result_chan), 0);
    chk({ph, "_rlock"}, 32'(result_lock), 0);
    chk({ph, "_rto"}, 32'(result_timeout), 0);
    chk({ph, "_rerr"}, 32'(result_err_cnt), 0);
    chk({ph, "_mask"}, 32'(chan_lock_mask), 0);
    chk({ph, "_sel"}, 32'(mon_chan_sel), 0);
    chk({ph, "_pnsel"}, 32'(mon_pn_seq_sel), 0);
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (result_valid) begin
      rv_cnt++;
      if (sb.size() == 0) chk("rv_unexpected", 32'(result_valid), 0);
      else begin
        e = sb.pop_front();
        chk("res_chan", 32'(result_chan), e.chan);
        chk("res_lock", 32'(result_lock), 32'(e.lock));
        chk("res_timeout", 32'(result_timeout), 32'(e.to));
        chk("res_err_cnt", 32'(result_err_cnt), e.err);
        chk("res_latency", cyc - last_evt, e.dly);
        last_evt = cyc;
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 0);
    // all channels lock cleanly; a stray start mid-scan is ignored
    push_clean();
    scan(4'd0, 16'(W));
    chk("busy_after_start", 32'(busy), 1);
    repeat (200) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(2000);
    chk("mask_clean", 32'(chan_lock_mask), 32'hF);
    chk("done_clean", done_cnt, 1);
    chk("rv_clean", rv_cnt, 4);
    chk("pnsel_pn9", 32'(mon_pn_seq_sel), 0);
    // channel 2 never locks
    bad_chan = 4'b0100;
    push(0, 1'b1, 1'b0, 0, LW);
    push(1, 1'b1, 1'b0, 0, LW + 1);
    push(2, 1'b0, 1'b1, 0, SET + TO + 1);
    push(3, 1'b1, 1'b0, 0, LW + 1);
    scan(4'd0, 16'(W));
    wait_idle(3000);
    chk("mask_timeout", 32'(chan_lock_mask), 32'hB);
    chk("done_timeout", done_cnt, 2);
    bad_chan = 4'b0000;
    // channel 1 sees 5 error cycles plus one oos cycle in its window
    err_chan = 1;
    push(0, 1'b1, 1'b0, 0, LW);
    push(1, 1'b0, 1'b0, 6, LW + 1);
    push(2, 1'b1, 1'b0, 0, LW + 1);
    push(3, 1'b1, 1'b0, 0, LW + 1);
    scan(4'd5, 16'(W));
    pn = 4'd0;
    chk("pnsel_pn23", 32'(mon_pn_seq_sel), 1);
    wait_idle(2000);
    chk("mask_err", 32'(chan_lock_mask), 32'hD);
    chk("done_err", done_cnt, 3);
    chk("pnsel_held", 32'(mon_pn_seq_sel), 1);
    err_chan = -1;
    // abort while channel 1 is measuring
    push(0, 1'b1, 1'b0, 0, LW);
    scan(4'd0, 16'(W));
    repeat (160) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    repeat (300) @(negedge clk);
    chk("abort_done", done_cnt, 3);
    chk("abort_rv", rv_cnt, 13);
    chk("abort_mask", 32'(chan_lock_mask), 32'h1);
    chk("abort_rchan", 32'(result_chan), 0);
    chk("abort_rlock", 32'(result_lock), 1);
    chk("abort_sb_empty", sb.size(), 0);
    // asynchronous reset while channel 0 waits for lock
    scan(4'd0, 16'(W));
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_clean();
    scan(4'd1, 16'(W));
    chk("pnsel_after_rst", 32'(mon_pn_seq_sel), 1);
    wait_idle(2000);
    chk("mask_after_rst", 32'(chan_lock_mask), 32'hF);
    chk("done_after_rst", done_cnt, 4);
    chk("sb_drained", sb.size(), 0);
    // 4-bit counter held at error for a 40-cycle window
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    n = 0;
    while (!s_rv && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("sat_rv", 32'(s_rv), 1);
    chk("sat_latency", n, 43);
    chk("sat_err_cnt", 32'(s_rerr), 15);
    chk("sat_lock", 32'(s_rlock), 1);
    chk("sat_timeout", 32'(s_rto), 0);
    chk("sat_chan", 32'(s_rchan), 0);
    chk("sat_sel", 32'(s_sel), 0);
    chk("sat_pnsel", 32'(s_pn), 0);
    @(negedge clk);
    chk("sat_done", 32'(s_done), 1);
    chk("sat_mask", 32'(s_mask), 1);
    @(negedge clk);
    chk("sat_busy", 32'(s_busy), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
